dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 42 ++++
 rtl/dmem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Signal bundle for dmem_arbiter: CPU requester, bridge requester and the memory port.
// The arbiter takes the slave view; requesters plus memory model take the master view.
interface dmem_arbiter_if;
  logic        c_req;
  logic        c_we;
  logic [1:0]  c_size;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_done;
  logic [31:0] c_rdata;
  logic        b_req;
  logic        b_we;
  logic [1:0]  b_size;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_done;
  logic [31:0] b_rdata;
  logic        err;
  logic        m_en;
  logic        m_we;
  logic [3:0]  m_be;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;

  modport slave (
    input  c_req, c_we, c_size, c_addr, c_wdata,
    input  b_req, b_we, b_size, b_addr, b_wdata,
    input  m_rdata, m_ready,
    output c_done, c_rdata, b_done, b_rdata, err,
    output m_en, m_we, m_be, m_addr, m_wdata
  );

  modport master (
    output c_req, c_we, c_size, c_addr, c_wdata,
    output b_req, b_we, b_size, b_addr, b_wdata,
    output m_rdata, m_ready,
    input  c_done, c_rdata, b_done, b_rdata, err,
    input  m_en, m_we, m_be, m_addr, m_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter between a CPU and a bridge requester onto one 32-bit data memory.
// Handles byte/half/word lane steering, misalignment errors and one-cycle done pulses.
module dmem_arbiter (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lo[0];
      2'b10:   misaligned = (lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   lane_be = 4'b0001 << lo;
      2'b01:   lane_be = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] w);
    case (size)
      2'b00:   lane_wdata = {4{w[7:0]}};
      2'b01:   lane_wdata = {2{w[15:0]}};
      2'b10:   lane_wdata = w;
      default: lane_wdata = 32'h0000_0000;
    endcase
  endfunction

  // Halves are always aligned here, so shifting by 8*lo equals shifting by 16*lo[1].
  function automatic logic [31:0] align_rdata(input logic [1:0] size, input logic [1:0] lo,
                                              input logic [31:0] r);
    logic [31:0] sh;
    sh = r >> {lo, 3'b000};
    case (size)
      2'b00:   align_rdata = {24'h00_0000, sh[7:0]};
      2'b01:   align_rdata = {16'h0000, sh[15:0]};
      2'b10:   align_rdata = r;
      default: align_rdata = 32'h0000_0000;
    endcase
  endfunction

  state_t      state_r, state_n;
  logic        last_cpu_r, last_cpu_n;
  logic        gnt_b_r, gnt_b_n;
  logic        we_r, we_n;
  logic        mis_r, mis_n;
  logic [1:0]  size_r, size_n;
  logic [31:0] addr_r, addr_n;
  logic [31:0] wdata_r, wdata_n;

  logic        m_en_r, m_en_n;
  logic        m_we_r, m_we_n;
  logic [3:0]  m_be_r, m_be_n;
  logic [29:0] m_addr_r, m_addr_n;
  logic [31:0] m_wdata_r, m_wdata_n;
  logic        c_done_r, c_done_n;
  logic        b_done_r, b_done_n;
  logic        err_r, err_n;
  logic [31:0] c_rdata_r, c_rdata_n;
  logic [31:0] b_rdata_r, b_rdata_n;

  logic        any_req_s;
  logic        win_b_s;
  logic [31:0] rd_s;

  // Next-state, grant/capture and registered-output decode.
  always_comb begin
    any_req_s  = bus.c_req | bus.b_req;
    win_b_s    = bus.b_req & (~bus.c_req | last_cpu_r);
    state_n    = state_r;
    last_cpu_n = last_cpu_r;
    gnt_b_n    = gnt_b_r;
    we_n       = we_r;
    size_n     = size_r;
    addr_n     = addr_r;
    wdata_n    = wdata_r;
    mis_n      = mis_r;

    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          gnt_b_n    = win_b_s;
          last_cpu_n = ~win_b_s;
          we_n       = win_b_s ? bus.b_we    : bus.c_we;
          size_n     = win_b_s ? bus.b_size  : bus.c_size;
          addr_n     = win_b_s ? bus.b_addr  : bus.c_addr;
          wdata_n    = win_b_s ? bus.b_wdata : bus.c_wdata;
          mis_n      = misaligned(size_n, addr_n[1:0]);
          state_n    = mis_n ? DONE : ACCESS;
        end else begin
          state_n = IDLE;
        end
      end
      ACCESS: begin
        if (bus.m_ready) begin
          state_n = DONE;
        end else begin
          state_n = ACCESS;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Memory port is registered from the next state so m_en and m_be always fall together.
    m_en_n = (state_n == ACCESS);
    if (m_en_n) begin
      m_we_n    = we_n;
      m_be_n    = lane_be(size_n, addr_n[1:0]);
      m_addr_n  = addr_n[31:2];
      m_wdata_n = lane_wdata(size_n, wdata_n);
    end else begin
      m_we_n    = 1'b0;
      m_be_n    = 4'b0000;
      m_addr_n  = 30'h0000_0000;
      m_wdata_n = 32'h0000_0000;
    end

    rd_s      = (state_r == ACCESS && !we_r) ? align_rdata(size_r, addr_r[1:0], bus.m_rdata)
                                             : 32'h0000_0000;
    c_done_n  = (state_n == DONE) & ~gnt_b_n;
    b_done_n  = (state_n == DONE) &  gnt_b_n;
    err_n     = (state_n == DONE) &  mis_n;
    c_rdata_n = c_done_n ? rd_s : 32'h0000_0000;
    b_rdata_n = b_done_n ? rd_s : 32'h0000_0000;
  end

  // State, captured request and output registers; reset leaves the bridge as last grantee.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      last_cpu_r <= 1'b0;
      gnt_b_r    <= 1'b0;
      we_r       <= 1'b0;
      mis_r      <= 1'b0;
      size_r     <= 2'b00;
      addr_r     <= 32'h0000_0000;
      wdata_r    <= 32'h0000_0000;
      m_en_r     <= 1'b0;
      m_we_r     <= 1'b0;
      m_be_r     <= 4'b0000;
      m_addr_r   <= 30'h0000_0000;
      m_wdata_r  <= 32'h0000_0000;
      c_done_r   <= 1'b0;
      b_done_r   <= 1'b0;
      err_r      <= 1'b0;
      c_rdata_r  <= 32'h0000_0000;
      b_rdata_r  <= 32'h0000_0000;
    end else begin
      state_r    <= state_n;
      last_cpu_r <= last_cpu_n;
      gnt_b_r    <= gnt_b_n;
      we_r       <= we_n;
      mis_r      <= mis_n;
      size_r     <= size_n;
      addr_r     <= addr_n;
      wdata_r    <= wdata_n;
      m_en_r     <= m_en_n;
      m_we_r     <= m_we_n;
      m_be_r     <= m_be_n;
      m_addr_r   <= m_addr_n;
      m_wdata_r  <= m_wdata_n;
      c_done_r   <= c_done_n;
      b_done_r   <= b_done_n;
      err_r      <= err_n;
      c_rdata_r  <= c_rdata_n;
      b_rdata_r  <= b_rdata_n;
    end
  end

  assign bus.m_en    = m_en_r;
  assign bus.m_we    = m_we_r;
  assign bus.m_be    = m_be_r;
  assign bus.m_addr  = m_addr_r;
  assign bus.m_wdata = m_wdata_r;
  assign bus.c_done  = c_done_r;
  assign bus.b_done  = b_done_r;
  assign bus.err     = err_r;
  assign bus.c_rdata = c_rdata_r;
  assign bus.b_rdata = b_rdata_r;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed vectors push expected done/memory events,
// a monitor pops and compares whenever the DUT presents them.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter_if bus ();
  dmem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        is_b;
    logic [31:0] rdata;
    logic        err;
    int          done_cyc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [29:0] addr;
    logic [31:0] wdata;
    int          en_cycles;
  } mem_t;

  typedef struct {
    logic        is_b;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          delay;
    logic [3:0]  be;
    logic [29:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    logic        err;
    logic        drop;
  } vec_t;

  resp_t       exp_q[$];
  mem_t        mem_q[$];
  vec_t        vecs[9];
  int          mem_delay = 0;
  logic [31:0] mem_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic is_b, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (is_b) begin
      bus.b_we = we; bus.b_size = size; bus.b_addr = addr; bus.b_wdata = wdata; bus.b_req = 1'b1;
    end else begin
      bus.c_we = we; bus.c_size = size; bus.c_addr = addr; bus.c_wdata = wdata; bus.c_req = 1'b1;
    end
  endtask

  task automatic wait_done(input logic is_b);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (is_b ? bus.b_done : bus.c_done) seen = 1'b1;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL done_timeout: no done for requester %0d within 60 cycles", is_b);
    end
    if (is_b) bus.b_req = 1'b0;
    else      bus.c_req = 1'b0;
  endtask

  // Memory model: ready after mem_delay ACCESS cycles; spurious ready while m_en is low.
  initial begin : responder
    int cnt;
    cnt = 0;
    bus.m_ready = 1'b0;
    bus.m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.m_en) begin
        bus.m_ready = (cnt == mem_delay);
        bus.m_rdata = (cnt == mem_delay) ? mem_rdata : 32'hDEAD_DEAD;
        cnt++;
      end else begin
        cnt = 0;
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'hDEAD_DEAD;
      end
    end
  end

  initial begin : monitor
    logic  prev_en;
    int    en_cnt;
    mem_t  cur;
    resp_t r;
    prev_en = 1'b0;
    en_cnt  = 0;
    cur     = '{1'b0, 4'h0, 30'h0, 32'h0, 0};
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_en = 1'b0;
        en_cnt  = 0;
      end else begin
        if (bus.c_done || bus.b_done) begin
          check("single_done", 32'(bus.c_done & bus.b_done), 32'h0);
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_done: c_done=%0b b_done=%0b with nothing pending",
                     bus.c_done, bus.b_done);
          end else begin
            r = exp_q.pop_front();
            check("done_port", 32'(bus.b_done), 32'(r.is_b));
            check("rdata", r.is_b ? bus.b_rdata : bus.c_rdata, r.rdata);
            check("other_rdata", r.is_b ? bus.c_rdata : bus.b_rdata, 32'h0);
            check("err", 32'(bus.err), 32'(r.err));
            if (r.done_cyc >= 0) check("latency", 32'(cyc), 32'(r.done_cyc));
          end
        end else begin
          check("quiet_outputs", bus.c_rdata | bus.b_rdata | 32'(bus.err), 32'h0);
        end
        if (bus.m_en) begin
          if (!prev_en) begin
            en_cnt = 0;
            if (mem_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_access: m_en high with no access pending");
            end else begin
              cur = mem_q.pop_front();
            end
          end
          check("m_we", 32'(bus.m_we), 32'(cur.we));
          check("m_be", 32'(bus.m_be), 32'(cur.be));
          check("m_addr", 32'(bus.m_addr), 32'(cur.addr));
          check("m_wdata", bus.m_wdata, cur.wdata);
          en_cnt++;
        end else begin
          check("m_be_idle", 32'(bus.m_be), 32'h0);
          if (prev_en) check("m_en_cycles", 32'(en_cnt), 32'(cur.en_cycles));
        end
        prev_en = bus.m_en;
      end
    end
  end

  initial begin : stimulus
    bit seen;
    int base;
    int n;
    vecs[0] = '{1'b0, 1'b1, 2'b00, 32'h1003, 32'h0000_00AB, 32'h0, 0,
                4'b1000, 30'h400, 32'hABAB_ABAB, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 2'b01, 32'h6, 32'h0, 32'hBEEF_1234, 4,
                4'b1100, 30'h1, 32'h0, 32'h0000_BEEF, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 2'b10, 32'h2, 32'h0, 32'h0, 0,
                4'b0000, 30'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 2'b00, 32'h11, 32'h0, 32'h4433_2211, 1,
                4'b0010, 30'h4, 32'h0, 32'h22, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 2'b01, 32'h2, 32'h1234_BEEF, 32'h0, 0,
                4'b1100, 30'h0, 32'hBEEF_BEEF, 32'h0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 2'b11, 32'h0, 32'h55, 32'h0, 0,
                4'b0000, 30'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 2'b01, 32'h1, 32'h0, 32'h0, 0,
                4'b0000, 30'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 2'b10, 32'h8, 32'h0, 32'hCAFE_F00D, 2,
                4'b1111, 30'h2, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 2'b00, 32'h7, 32'h0, 32'h80AA_BBCC, 0,
                4'b1000, 30'h1, 32'h0, 32'h80, 1'b0, 1'b0};

    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_size = 2'b00; bus.c_addr = 32'h0; bus.c_wdata = 32'h0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_size = 2'b00; bus.b_addr = 32'h0; bus.b_wdata = 32'h0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_m_en", 32'(bus.m_en), 32'h0);
    check("rst_m_we", 32'(bus.m_we), 32'h0);
    check("rst_m_be", 32'(bus.m_be), 32'h0);
    check("rst_m_addr", 32'(bus.m_addr), 32'h0);
    check("rst_m_wdata", bus.m_wdata, 32'h0);
    check("rst_done", 32'({bus.c_done, bus.b_done, bus.err}), 32'h0);
    check("rst_rdata", bus.c_rdata | bus.b_rdata, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      mem_delay = vecs[i].delay;
      mem_rdata = vecs[i].mrdata;
      if (!vecs[i].err)
        mem_q.push_back('{vecs[i].we, vecs[i].be, vecs[i].maddr, vecs[i].mwdata, vecs[i].delay + 1});
      exp_q.push_back('{vecs[i].is_b, vecs[i].rdata, vecs[i].err,
                        cyc + (vecs[i].err ? 1 : 2 + vecs[i].delay)});
      drive(vecs[i].is_b, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].drop) begin
        repeat (2) @(negedge clk);
        if (vecs[i].is_b) bus.b_req = 1'b0;
        else              bus.c_req = 1'b0;
      end
      wait_done(vecs[i].is_b);
    end

    // Abort a long CPU access with reset between clock edges.
    @(negedge clk);
    mem_delay = 20;
    mem_q.push_back('{1'b1, 4'b1111, 30'h10, 32'h77, 0});
    drive(1'b0, 1'b1, 2'b10, 32'h40, 32'h77);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.m_en) seen = 1'b1;
    end
    check("abort_m_en_seen", 32'(seen), 32'h1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_m_en", 32'(bus.m_en), 32'h0);
    check("abort_m_be", 32'(bus.m_be), 32'h0);
    check("abort_done", 32'({bus.c_done, bus.b_done}), 32'h0);
    @(negedge clk);
    bus.c_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Both requesters hold word requests; grants alternate starting with the CPU.
    mem_delay = 0;
    mem_rdata = 32'h0BAD_BEEF;
    base = cyc;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 1) begin
        exp_q.push_back('{1'b1, 32'h0BAD_BEEF, 1'b0, base + 2 + 3 * k});
        mem_q.push_back('{1'b0, 4'b1111, 30'h80, 32'h0, 1});
      end else begin
        exp_q.push_back('{1'b0, 32'h0, 1'b0, base + 2 + 3 * k});
        mem_q.push_back('{1'b1, 4'b1111, 30'h40, 32'h1111_1111, 1});
      end
    end
    drive(1'b0, 1'b1, 2'b10, 32'h100, 32'h1111_1111);
    drive(1'b1, 1'b0, 2'b10, 32'h200, 32'h0);
    n = 0;
    for (int i = 0; i < 60 && n < 6; i++) begin
      @(negedge clk);
      if (bus.c_done || bus.b_done) n++;
    end
    check("contention_dones", 32'(n), 32'd6);
    bus.c_req = 1'b0;
    bus.b_req = 1'b0;

    repeat (5) @(negedge clk);
    check("resp_queue_empty", 32'(exp_q.size()), 32'h0);
    check("mem_queue_empty", 32'(mem_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
